// File: rtl/cdc_toggle_req_tx_if.sv
// ---------------------------------------------------------------------------
// cdc_toggle_req_tx_if
//
// Purpose:
//   Bundles the signals of the fast-domain toggle request transmitter. Two
//   groups are carried:
//     - the local accept handshake (in_valid / in_data / in_ready) together
//       with the status flags busy and drop_pulse;
//     - the crossing itself (tx_req / tx_data towards the slow domain and
//       ack_async coming back from it).
//
// Modports:
//   master : the side that offers words and plays the slow-domain receiver
//            (drives in_valid, in_data, ack_async).
//   slave  : the transmitter (drives in_ready, tx_req, tx_data, busy,
//            drop_pulse).
//
// Parameters:
//   WIDTH  payload width in bits; must match the transmitter's WIDTH.
// ---------------------------------------------------------------------------
interface cdc_toggle_req_tx_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             tx_req;
  logic [WIDTH-1:0] tx_data;
  logic             ack_async;
  logic             busy;
  logic             drop_pulse;

  modport master (
    output in_valid,
    output in_data,
    output ack_async,
    input  in_ready,
    input  tx_req,
    input  tx_data,
    input  busy,
    input  drop_pulse
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  ack_async,
    output in_ready,
    output tx_req,
    output tx_data,
    output busy,
    output drop_pulse
  );

endinterface

// File: rtl/cdc_toggle_req_tx.sv
// ---------------------------------------------------------------------------
// cdc_toggle_req_tx
//
// Purpose:
//   Fast-domain transmitter of a fast-to-slow toggle req/ack handshake.
//   A word offered with a one-cycle in_valid pulse is captured into tx_data
//   and announced to the slow domain by flipping the level of tx_req. The
//   slow-domain receiver samples tx_data and flips ack back; that ack is
//   brought into fast_clk through a SYNC_STAGES-deep flop chain and, once
//   it equals tx_req again, the transmitter re-opens for the next word.
//   tx_data never changes while a word is outstanding, so the slow side
//   may sample it at any time after it sees the tx_req edge.
//
// Ports:
//   fast_clk          sole clock, rising edge.
//   reset_n           asynchronous active-low reset (deassertion is
//                     synchronised outside this block).
//   bus (slave)       in_valid   one-cycle request to send in_data
//                     in_data    payload, sampled when in_valid && in_ready
//                     in_ready   a word can be accepted this cycle
//                     tx_req     request toggle level to the slow domain
//                     tx_data    held payload to the slow domain
//                     ack_async  ack toggle from the slow domain (async)
//                     busy       a word is outstanding (tx_req != ack_sync)
//                     drop_pulse one-cycle flag: an offered word was lost
//
// Parameters:
//   WIDTH        payload width (default 8).
//   SYNC_STAGES  flops in the ack synchroniser, legal range 2..4 (default 2).
//
// Build option:
//   CDC_TOGGLE_REQ_TX_PEND_EN  when defined, adds a one-entry pending
//                              register so that one further word can be
//                              accepted while a word is in flight; it is
//                              launched in the same cycle the ack returns.
//                              Without the macro the block accepts only
//                              in IDLE.
// ---------------------------------------------------------------------------
module cdc_toggle_req_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic                fast_clk,
  input logic                reset_n,
  cdc_toggle_req_tx_if.slave bus
);

  // Reject synchroniser depths outside the supported range at elaboration.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("cdc_toggle_req_tx: SYNC_STAGES must be within 2..4");
  end

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_sync;
  logic                   ack_sync_next;
  logic                   ack_match;

  logic                   tx_req_q;
  logic                   tx_req_d;
  logic [WIDTH-1:0]       tx_data_q;
  logic [WIDTH-1:0]       tx_data_d;

  logic                   busy_q;
  logic                   busy_d;
  logic                   drop_q;
  logic                   drop_d;
  logic                   in_ready;

`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
  logic                   pend_full_q;
  logic                   pend_full_d;
  logic [WIDTH-1:0]       pend_q;
  logic [WIDTH-1:0]       pend_d;
`endif

  // Ack synchroniser: ack_async enters bit 0 and walks up the chain; the
  // top bit is the only synchronised view of ack used anywhere. Nothing
  // else in the block looks at ack_async directly.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_async};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

  // Value ack_sync will take after the coming edge; lets busy be computed
  // as a register that always equals tx_req != ack_sync of the same cycle.
  assign ack_sync_next = ack_sync_q[SYNC_STAGES-2];

  // The receiver has acknowledged the word currently on tx_req.
  assign ack_match = (ack_sync == tx_req_q);

  // Next-state and output logic. Everything holds by default; only an
  // accepted word moves tx_req/tx_data, and only an ack match leaves
  // WAIT_ACK. in_ready is a pure decode of the registered state (and of
  // pend_full when the pending slot exists), so it never depends on the
  // asynchronous ack.
  always_comb begin
    state_d   = state_q;
    tx_req_d  = tx_req_q;
    tx_data_d = tx_data_q;
    in_ready  = 1'b0;
`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
`endif

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          tx_data_d = bus.in_data;
          tx_req_d  = ~tx_req_q;
          state_d   = WAIT_ACK;
        end
      end

      WAIT_ACK: begin
`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
        in_ready = ~pend_full_q;
        if (ack_match) begin
          if (pend_full_q) begin
            // Launch the parked word right away; a word offered in this
            // very cycle sees in_ready=0 and is dropped.
            tx_data_d   = pend_q;
            tx_req_d    = ~tx_req_q;
            pend_full_d = 1'b0;
          end else if (bus.in_valid) begin
            // Slot is empty and a word arrives exactly on the ack match:
            // it would otherwise be stranded in pend with the FSM in
            // IDLE, so it is launched directly instead.
            tx_data_d = bus.in_data;
            tx_req_d  = ~tx_req_q;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.in_valid && !pend_full_q) begin
          pend_d      = bus.in_data;
          pend_full_d = 1'b1;
        end
`else
        in_ready = 1'b0;
        if (ack_match) begin
          state_d = IDLE;
        end
`endif
      end
    endcase

    busy_d = (tx_req_d != ack_sync_next);
    drop_d = bus.in_valid && !in_ready;
  end

  // State and output registers. tx_req and tx_data come straight from
  // flops so the slow domain sees glitch-free levels.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tx_req_q  <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_req_q  <= tx_req_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
    end
  end

`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
  // One-entry pending slot for a word offered while another is in flight.
  always_ff @(posedge fast_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_full_q <= 1'b0;
      pend_q      <= '0;
    end else begin
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
    end
  end
`endif

  assign bus.in_ready   = in_ready;
  assign bus.tx_req     = tx_req_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.drop_pulse = drop_q;

endmodule

// File: tb/tb_cdc_toggle_req_tx.sv
// ---------------------------------------------------------------------------
// tb_cdc_toggle_req_tx
//
// Self-checking bench for cdc_toggle_req_tx. The bench plays both the word
// source and the slow-domain receiver. A behavioural model tracks, in terms
// of edge numbers, when words are accepted, when the receiver returns ack,
// when busy clears and when the block re-opens; DUT outputs are compared
// against it after each rising edge (sampled on the falling edge).
// ---------------------------------------------------------------------------
module tb_cdc_toggle_req_tx;

  localparam int WIDTH = 8;
  localparam int S     = 2;
  localparam int INF   = 32'h3fff_ffff;
`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
  localparam bit PEND  = 1'b1;
`else
  localparam bit PEND  = 1'b0;
`endif

  logic fast_clk = 1'b0;
  logic reset_n;

  always #5 fast_clk = ~fast_clk;

  cdc_toggle_req_tx_if #(.WIDTH(WIDTH)) bus ();

  cdc_toggle_req_tx #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (S)
  ) dut (
    .fast_clk (fast_clk),
    .reset_n  (reset_n),
    .bus      (bus.slave)
  );

  // Reference model state
  int         cyc;
  logic       exp_req;
  logic [7:0] exp_data;
  logic       exp_drop;
  logic       busy_m;
  logic       waiting;
  logic       pend_full_m;
  logic [7:0] pend_data_m;
  int         match_edge;
  int         ack_sched;
  int         ack_t;
  int         rx_lat;

  int tests_run;
  int tests_failed;

  function automatic bit exp_ready();
    return !waiting || (PEND && !pend_full_m);
  endfunction

  task automatic model_reset();
    exp_req     = 1'b0;
    exp_data    = 8'h00;
    exp_drop    = 1'b0;
    busy_m      = 1'b0;
    waiting     = 1'b0;
    pend_full_m = 1'b0;
    pend_data_m = 8'h00;
    match_edge  = INF;
    ack_sched   = -1;
    ack_t       = -1;
  endtask

  // A word goes out: tx_req flips, the receiver will ack rx_lat edges later.
  task automatic model_send(input logic [7:0] x);
    exp_req    = ~exp_req;
    exp_data   = x;
    busy_m     = 1'b1;
    waiting    = 1'b1;
    match_edge = INF;
    ack_sched  = cyc + rx_lat;
  endtask

  // One clock: model reacts to the inputs sampled at the rising edge, then
  // on the falling edge the receiver may toggle ack and inputs are cleared.
  // An ack toggled after edge t reaches ack_sync after edge t+S, and the
  // FSM acts on the match at edge t+S+1.
  task automatic tick();
    logic       v;
    logic [7:0] d;
    @(posedge fast_clk);
    cyc++;
    v = bus.in_valid;
    d = bus.in_data;
    exp_drop = 1'b0;
    if (ack_t >= 0 && cyc == ack_t + S) busy_m = 1'b0;
    if (waiting && cyc == match_edge) begin
      if (PEND && pend_full_m) begin
        model_send(pend_data_m);
        pend_full_m = 1'b0;
        exp_drop    = v;
      end else if (PEND && v) begin
        model_send(d);
      end else begin
        waiting    = 1'b0;
        match_edge = INF;
        exp_drop   = v;
      end
    end else if (v) begin
      if (!waiting) begin
        model_send(d);
      end else if (PEND && !pend_full_m) begin
        pend_full_m = 1'b1;
        pend_data_m = d;
      end else begin
        exp_drop = 1'b1;
      end
    end
    @(negedge fast_clk);
    bus.in_valid = 1'b0;
    if (cyc == ack_sched) begin
      bus.ack_async = ~bus.ack_async;
      ack_t         = cyc;
      match_edge    = cyc + S + 1;
      ack_sched     = -1;
    end
  endtask

  task automatic drive(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((waiting || busy_m || ack_sched >= 0) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    if (guard >= 100) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait_idle: got timeout expected idle within 100 cycles");
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.ack_async = 1'b0;
    model_reset();
    repeat (5) tick();
    reset_n = 1'b1;
    #1;
    tests_run++;
    if (bus.tx_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_tx_req: got %0b expected 0", bus.tx_req);
    end
    tests_run++;
    if (bus.tx_data !== 8'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset_tx_data: got %02h expected 00", bus.tx_data);
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %0b expected 1", bus.in_ready);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %0b expected 0", bus.busy);
    end
    tests_run++;
    if (bus.drop_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_drop: got %0b expected 0", bus.drop_pulse);
    end
  endtask

  // Single word with a 4-cycle receiver: tx_data must hold d throughout,
  // busy/in_ready/tx_req must follow the ack timeline.
  task automatic test_single_word(input logic [7:0] d);
    rx_lat = 4;
    drive(d);
    tick();
    for (int i = 0; i < 12; i++) begin
      tests_run++;
      if (bus.tx_data !== d) begin
        tests_failed++;
        $display("[TB] FAIL single_tx_data[%0d]: got %02h expected %02h", i, bus.tx_data, d);
      end
      tests_run++;
      if (bus.busy !== busy_m) begin
        tests_failed++;
        $display("[TB] FAIL single_busy[%0d]: got %0b expected %0b", i, bus.busy, busy_m);
      end
      tests_run++;
      if (bus.in_ready !== exp_ready()) begin
        tests_failed++;
        $display("[TB] FAIL single_in_ready[%0d]: got %0b expected %0b", i, bus.in_ready, exp_ready());
      end
      tests_run++;
      if (bus.tx_req !== exp_req) begin
        tests_failed++;
        $display("[TB] FAIL single_tx_req[%0d]: got %0b expected %0b", i, bus.tx_req, exp_req);
      end
      tick();
    end
    wait_idle();
  endtask

  task automatic test_drop();
    rx_lat = 4;
    drive(8'h3C);
    tick();
    drive(8'h77);
    tick();
    tests_run++;
    if (bus.drop_pulse !== exp_drop) begin
      tests_failed++;
      $display("[TB] FAIL drop_pulse_high: got %0b expected %0b", bus.drop_pulse, exp_drop);
    end
    tests_run++;
    if (bus.tx_data !== exp_data) begin
      tests_failed++;
      $display("[TB] FAIL drop_tx_data: got %02h expected %02h", bus.tx_data, exp_data);
    end
    tick();
    tests_run++;
    if (bus.drop_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL drop_pulse_width: got %0b expected 0", bus.drop_pulse);
    end
    wait_idle();
    tests_run++;
    if (bus.tx_req !== exp_req || bus.tx_data !== exp_data) begin
      tests_failed++;
      $display("[TB] FAIL drop_final: got req %0b data %02h expected req %0b data %02h",
               bus.tx_req, bus.tx_data, exp_req, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic r0;
    int   guard;
    rx_lat = 1;
    r0     = exp_req;
    drive(8'h01);
    tick();
    guard = 0;
    while (!exp_ready() && guard < 50) begin
      tick();
      guard++;
    end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL b2b_in_ready: got %0b expected 1", bus.in_ready);
    end
    drive(8'h02);
    tick();
    tests_run++;
    if (bus.drop_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_drop: got %0b expected 0", bus.drop_pulse);
    end
    wait_idle();
    tests_run++;
    if (bus.tx_data !== 8'h02) begin
      tests_failed++;
      $display("[TB] FAIL b2b_tx_data: got %02h expected 02", bus.tx_data);
    end
    tests_run++;
    if (bus.tx_req !== r0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_tx_req: got %0b expected %0b", bus.tx_req, r0);
    end
  endtask

  // Reset asserted away from any clock edge while waiting for ack; the
  // receiver side is reset in the same window (ack_async back to 0).
  task automatic test_reset_mid();
    rx_lat = 30;
    drive(8'hFF);
    tick();
    tick();
    tests_run++;
    if (bus.tx_data !== 8'hFF || bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_pre: got data %02h ready %0b expected data ff ready 0",
               bus.tx_data, bus.in_ready);
    end
    #2;
    reset_n       = 1'b0;
    bus.ack_async = 1'b0;
    #1;
    tests_run++;
    if (bus.tx_req !== 1'b0 || bus.tx_data !== 8'h00 || bus.in_ready !== 1'b1 ||
        bus.busy !== 1'b0 || bus.drop_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_async: got req %0b data %02h ready %0b busy %0b drop %0b expected 0 00 1 0 0",
               bus.tx_req, bus.tx_data, bus.in_ready, bus.busy, bus.drop_pulse);
    end
    model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
  task automatic test_pend();
    int guard;
    rx_lat = 3;
    drive(8'h11);
    tick();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pend_ready: got %0b expected 1", bus.in_ready);
    end
    drive(8'h22);
    tick();
    tests_run++;
    if (bus.drop_pulse !== 1'b0 || bus.tx_data !== 8'h11) begin
      tests_failed++;
      $display("[TB] FAIL pend_store: got drop %0b data %02h expected drop 0 data 11",
               bus.drop_pulse, bus.tx_data);
    end
    drive(8'h33);
    tick();
    tests_run++;
    if (bus.drop_pulse !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pend_full_drop: got %0b expected 1", bus.drop_pulse);
    end
    guard = 0;
    while (exp_data != 8'h22 && guard < 50) begin
      tick();
      guard++;
    end
    tests_run++;
    if (bus.tx_data !== 8'h22 || bus.tx_req !== exp_req || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pend_launch: got data %02h req %0b busy %0b expected data 22 req %0b busy 1",
               bus.tx_data, bus.tx_req, bus.busy, exp_req);
    end
    wait_idle();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 2) == 0);
      bus.in_data  = 8'($urandom);
      rx_lat       = int'($urandom_range(0, 6));
      tick();
      tests_run++;
      if (bus.tx_req !== exp_req || bus.tx_data !== exp_data || bus.in_ready !== exp_ready() ||
          bus.busy !== busy_m || bus.drop_pulse !== exp_drop) begin
        tests_failed++;
        $display("[TB] FAIL random[%0d]: got req %0b data %02h ready %0b busy %0b drop %0b expected %0b %02h %0b %0b %0b",
                 i, bus.tx_req, bus.tx_data, bus.in_ready, bus.busy, bus.drop_pulse,
                 exp_req, exp_data, exp_ready(), busy_m, exp_drop);
      end
    end
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc           = 0;
    tests_run     = 0;
    tests_failed  = 0;
    rx_lat        = 4;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.ack_async = 1'b0;
    model_reset();

    test_reset();
    test_single_word(8'hA5);
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_single_word(8'h5A);
`ifdef CDC_TOGGLE_REQ_TX_PEND_EN
    test_pend();
`endif
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cdc_toggle_req_tx.md
Name: cdc_toggle_req_tx

Overview:
- Source-side (fast domain) transmitter of a fast-to-slow toggle req/ack handshake.
- Mirror of the existing slow-to-fast sync path. It captures a WIDTH-bit word on a one-cycle valid pulse in the fast domain.
- It holds that word stable on tx_data and signals a new word by toggling the tx_req level.
- The slow-domain receiver samples the word and toggles ack back. This block synchronises ack internally and re-opens for the next word.

Parameters:
- WIDTH, 8, payload width in bits.
- SYNC_STAGES, 2, flops in the ack synchroniser chain. Legal values: 2 to 4.

Ports:
- fast_clk  input  1  sole clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- in_valid  input  1  one-cycle request to send in_data.
- in_data  input  WIDTH  payload; sampled only when in_valid && in_ready.
- in_ready  output  1  block can accept a word this cycle.
- tx_req  output  1  request toggle level, routed to the slow domain. Registered, glitch-free.
- tx_data  output  WIDTH  held payload, routed to the slow domain. Registered.
- ack_async  input  1  ack toggle from the slow domain; asynchronous to fast_clk.
- busy  output  1  a word is outstanding (tx_req != ack_sync).
- drop_pulse  output  1  one-cycle flag: in_valid arrived while in_ready=0 and the word was lost.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - tx_req=0, tx_data=0, in_ready=1, busy=0, drop_pulse=0.
  - All synchroniser flops = 0; FSM = IDLE.
- Ack synchroniser: ack_async passes through SYNC_STAGES flops. ack_sync is the last stage. No other logic reads ack_async.
- FSM states: IDLE, WAIT_ACK.
- IDLE:
  - in_ready=1.
  - If in_valid: tx_data <= in_data, tx_req <= ~tx_req, go to WAIT_ACK.
  - The new tx_req/tx_data are visible one cycle after the accept edge.
- WAIT_ACK:
  - in_ready=0.
  - When ack_sync == tx_req, go to IDLE; in_ready=1 the following cycle.
  - Minimum turnaround (ack returned instantly) = SYNC_STAGES+1 fast cycles from the accept edge.
- busy = (tx_req != ack_sync), registered as part of the FSM state.
- tx_data changes only on an accepted word. It is guaranteed constant whenever busy=1.
- drop_pulse: asserted for exactly one cycle, the cycle after any in_valid seen with in_ready=0. The word is discarded and FSM/tx_data are untouched.
- Simultaneous events:
  - An in_valid in the same cycle that WAIT_ACK detects the ack match is dropped, because in_ready is still 0 that cycle.
  - An ack_sync change while in IDLE (no request outstanding) is ignored; no state change.
- Reset mid-operation: everything clears immediately, including an outstanding request. The slow-side receiver must be reset in the same reset window. Behaviour with one-sided reset is not defined.
- Throughput: at most one word per (SYNC_STAGES + slow-side ack latency + 1) fast cycles.

Optional Feature:
- Macro: CDC_TOGGLE_REQ_TX_PEND_EN.
- Enabled: adds a one-entry pending register and pend_full flag.
  - In WAIT_ACK, in_ready = ~pend_full, and an accepted word goes to pend.
  - On ack match with pend_full=1: same cycle tx_data <= pend, tx_req toggles again, pend_full clears, FSM stays in WAIT_ACK.
  - drop_pulse fires only when pend is full.
  - Reset clears pend_full.
- Disabled: no pending storage; in_ready = (FSM==IDLE); behaviour exactly as above.

Test Plan:
- Reset hold for 5 cycles, then release -> tx_req=0, tx_data=8'h00, in_ready=1, busy=0, drop_pulse=0.
- in_valid with in_data=8'hA5; model toggles ack_async 4 cycles after tx_req flips -> tx_data=8'hA5 stable throughout; busy high from accept+1 until 2 cycles after the ack toggle; in_ready returns to 1 the next cycle.
- Send 8'h3C, then a second in_valid with 8'h77 while busy -> drop_pulse=1 for one cycle; tx_data stays 8'h3C; tx_req toggles only once.
- Back-to-back: send 8'h01, then pulse in_valid with 8'h02 on the first cycle in_ready=1 -> accepted; tx_req toggles twice total; tx_data ends at 8'h02.
- Assert reset_n=0 while in WAIT_ACK with tx_data=8'hFF -> outputs return to reset values asynchronously; the first post-reset send behaves as in scenario 2.
- With CDC_TOGGLE_REQ_TX_PEND_EN: send 8'h11, then 8'h22 while busy -> no drop; on ack, tx_data=8'h22 and tx_req toggles again in the same cycle; a third in_valid while pend is full -> drop_pulse.
